// File: rtl/fg_dac_pkg.sv
// Shared constants for the function-generator DAC write sequencer: state encoding,
// default timing and the saturating overrun-count update.
package fg_dac_pkg;

    localparam int OVR_CNT_WIDTH       = 8;
    localparam int DEF_WR_PULSE_CYCLES = 2;
    localparam int DEF_SETTLE_CYCLES   = 500;
    localparam int DEF_CNT_WIDTH       = 16;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SETUP  = 3'd1;
    localparam logic [2:0] ST_WR_LOW = 3'd2;
    localparam logic [2:0] ST_HOLD   = 3'd3;
    localparam logic [2:0] ST_SETTLE = 3'd4;
    localparam logic [2:0] ST_CLEAR  = 3'd5;

    localparam logic [OVR_CNT_WIDTH-1:0] OVR_CNT_MAX = '1;

    // Clear takes effect first, so a drop in the same cycle leaves the count at 1.
    function automatic logic [OVR_CNT_WIDTH-1:0] ovr_cnt_update(
        input logic [OVR_CNT_WIDTH-1:0] cnt,
        input logic                     clr,
        input logic                     drop
    );
        logic [OVR_CNT_WIDTH-1:0] base;
        logic [OVR_CNT_WIDTH-1:0] result;
        base   = clr ? '0 : cnt;
        result = base;
        if (drop && (base != OVR_CNT_MAX)) begin
            result = base + OVR_CNT_WIDTH'(1);
        end
        return result;
    endfunction

endpackage

// File: rtl/fg_down_counter.sv
// Loadable down counter with zero flag; holds at zero instead of wrapping.
module fg_down_counter #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 srst,
    input  logic                 load,
    input  logic [CNT_WIDTH-1:0] load_val,
    input  logic                 dec,
    output logic                 zero
);

    logic [CNT_WIDTH-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (dec && (count_reg != '0)) begin
            count_reg <= count_reg - CNT_WIDTH'(1);
        end
    end

    assign zero = (count_reg == '0);

endmodule

// File: rtl/fg_dac_write_sequencer.sv
// Drives the parallel DAC write cycle (setup, WR_n pulse, hold, settle) and the DAC clear
// pulse from the generator sample stream, counting samples dropped while not ready.
module fg_dac_write_sequencer
    import fg_dac_pkg::*;
#(
    parameter int BITWIDTH        = 8,
    parameter int WR_PULSE_CYCLES = DEF_WR_PULSE_CYCLES,
    parameter int SETTLE_CYCLES   = DEF_SETTLE_CYCLES,
    parameter int CNT_WIDTH       = DEF_CNT_WIDTH
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     enable_i,
    input  logic [BITWIDTH-1:0]      sample_i,
    input  logic                     sampleValid_i,
    output logic                     sampleReady_o,
    input  logic                     clearReq_i,
    output logic [BITWIDTH-1:0]      dac_data_o,
    output logic                     dac_wr_n_o,
    output logic                     dac_clr_n_o,
    output logic                     dac_pd_n_o,
    output logic                     busy_o,
    output logic [OVR_CNT_WIDTH-1:0] overrunCnt_o,
    input  logic                     overrunClr_i
);

    localparam logic [CNT_WIDTH-1:0] WR_LOAD     = CNT_WIDTH'(WR_PULSE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] SETTLE_LOAD = CNT_WIDTH'(SETTLE_CYCLES - 1);

    logic [2:0]               state_reg, state_next;
    logic [BITWIDTH-1:0]      data_reg, data_next;
    logic                     wr_n_reg, wr_n_next;
    logic                     clr_n_reg, clr_n_next;
    logic                     pd_n_reg;
    logic [OVR_CNT_WIDTH-1:0] ovr_cnt_reg;
    logic                     clr_prev_reg;
    logic                     clr_pending_reg, clr_pending_next;

    logic                     cnt_load, cnt_dec, cnt_zero;
    logic [CNT_WIDTH-1:0]     cnt_load_val;
    logic                     clr_rise, sample_ready, accept, drop, enter_clear;

    assign clr_rise     = clearReq_i & ~clr_prev_reg;
    // A latched clear is served before any sample, so never advertise ready while one waits.
    assign sample_ready = (state_reg == ST_IDLE) & enable_i & ~clearReq_i & ~clr_pending_reg;
    assign accept       = sampleValid_i & sample_ready;
    assign drop         = sampleValid_i & ~sample_ready;

    fg_down_counter #(
        .CNT_WIDTH(CNT_WIDTH)
    ) u_timer (
        .clk      (clk_i),
        .srst     (rst_i),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg       <= ST_IDLE;
            data_reg        <= '0;
            wr_n_reg        <= 1'b1;
            clr_n_reg       <= 1'b0;
            pd_n_reg        <= 1'b0;
            ovr_cnt_reg     <= '0;
            clr_prev_reg    <= 1'b0;
            clr_pending_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            data_reg        <= data_next;
            wr_n_reg        <= wr_n_next;
            clr_n_reg       <= clr_n_next;
            pd_n_reg        <= enable_i;
            ovr_cnt_reg     <= ovr_cnt_update(ovr_cnt_reg, overrunClr_i, drop);
            clr_prev_reg    <= clearReq_i;
            clr_pending_reg <= clr_pending_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_dec      = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (clr_rise || clr_pending_reg) begin
                    state_next   = ST_CLEAR;
                    cnt_load     = 1'b1;
                    cnt_load_val = WR_LOAD;
                end else if (accept) begin
                    state_next = ST_SETUP;
                end
            end
            ST_SETUP: begin
                state_next   = ST_WR_LOW;
                cnt_load     = 1'b1;
                cnt_load_val = WR_LOAD;
            end
            ST_WR_LOW: begin
                if (cnt_zero) state_next = ST_HOLD;
                else          cnt_dec    = 1'b1;
            end
            ST_HOLD: begin
                state_next   = ST_SETTLE;
                cnt_load     = 1'b1;
                cnt_load_val = SETTLE_LOAD;
            end
            ST_SETTLE: begin
                if (cnt_zero) state_next = ST_IDLE;
                else          cnt_dec    = 1'b1;
            end
            ST_CLEAR: begin
                if (cnt_zero) begin
                    state_next   = ST_SETTLE;
                    cnt_load     = 1'b1;
                    cnt_load_val = SETTLE_LOAD;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Pin registers are loaded from the next state so each pin lines up with its state.
    always_comb begin
        enter_clear      = (state_reg == ST_IDLE) && (state_next == ST_CLEAR);
        data_next        = data_reg;
        if (enter_clear) begin
            data_next = '0;
        end else if (accept) begin
            data_next = sample_i;
        end
        wr_n_next        = (state_next != ST_WR_LOW);
        clr_n_next       = (state_next != ST_CLEAR);
        clr_pending_next = (clr_pending_reg | clr_rise) & ~enter_clear;
    end

    assign sampleReady_o = sample_ready;
    assign dac_data_o    = data_reg;
    assign dac_wr_n_o    = wr_n_reg;
    assign dac_clr_n_o   = clr_n_reg;
    assign dac_pd_n_o    = pd_n_reg;
    assign busy_o        = (state_reg != ST_IDLE);
    assign overrunCnt_o  = ovr_cnt_reg;

endmodule

// File: tb/tb_fg_dac_write_sequencer.sv
// Directed bench for fg_dac_write_sequencer with P=2, S=5; cycle c is the interval after edge c.
module tb_fg_dac_write_sequencer;

    logic       clk;
    logic       rst;
    logic       enable;
    logic [7:0] sample;
    logic       valid;
    logic       ready;
    logic       clear_req;
    logic [7:0] dac_data;
    logic       wr_n;
    logic       clr_n;
    logic       pd_n;
    logic       busy;
    logic [7:0] ovr_cnt;
    logic       ovr_clr;

    int checks = 0;
    int errors = 0;

    fg_dac_write_sequencer #(
        .BITWIDTH        (8),
        .WR_PULSE_CYCLES (2),
        .SETTLE_CYCLES   (5),
        .CNT_WIDTH       (16)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .enable_i      (enable),
        .sample_i      (sample),
        .sampleValid_i (valid),
        .sampleReady_o (ready),
        .clearReq_i    (clear_req),
        .dac_data_o    (dac_data),
        .dac_wr_n_o    (wr_n),
        .dac_clr_n_o   (clr_n),
        .dac_pd_n_o    (pd_n),
        .busy_o        (busy),
        .overrunCnt_o  (ovr_cnt),
        .overrunClr_i  (ovr_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; sample = '0; valid = 1'b0;
        clear_req = 1'b0; ovr_clr = 1'b0;

        // Reset
        repeat (3) cyc();
        chk("rst_wr_n", wr_n, 1);
        chk("rst_clr_n", clr_n, 0);
        chk("rst_pd_n", pd_n, 0);
        chk("rst_data", dac_data, 0);
        chk("rst_cnt", ovr_cnt, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        cyc();
        chk("rel_clr_n", clr_n, 1);
        chk("rel_ready_dis", ready, 0);
        enable = 1'b1;
        cyc();
        chk("en_pd_n", pd_n, 1);
        chk("en_ready", ready, 1);
        $display("reset sequence done");

        // Single write of 0xA5
        valid = 1'b1; sample = 8'hA5;
        #1;
        chk("a_ready_c0", ready, 1);
        for (int c = 1; c <= 10; c++) begin
            cyc();
            valid = 1'b0;
            #1;
            chk("a_data", dac_data, 8'hA5);
            chk("a_wr_n", wr_n, (c == 2 || c == 3) ? 0 : 1);
            chk("a_busy", busy, (c <= 9) ? 1 : 0);
            chk("a_ready", ready, (c == 10) ? 1 : 0);
        end
        $display("write 0xA5 done");

        // Strobes at 0,4,9,10: 0 and 10 accepted, 4 and 9 dropped
        for (int c = 0; c <= 20; c++) begin
            if (c > 0) cyc();
            valid  = (c == 0 || c == 4 || c == 9 || c == 10);
            sample = (c == 0) ? 8'h3C : (c == 4) ? 8'h11 : (c == 9) ? 8'h22 : 8'h5A;
            #1;
            chk("b_ready", ready, (c == 0 || c == 10 || c == 20) ? 1 : 0);
            chk("b_wr_n", wr_n, (c == 2 || c == 3 || c == 12 || c == 13) ? 0 : 1);
            if (c > 0) chk("b_data", dac_data, (c <= 10) ? 8'h3C : 8'h5A);
        end
        valid = 1'b0;
        chk("b_overrun", ovr_cnt, 2);
        $display("strobe train done overrun=%0d", ovr_cnt);

        // Clear request rising mid-write; strobe while the clear is pending is dropped
        for (int c = 0; c <= 18; c++) begin
            if (c > 0) cyc();
            valid  = (c == 0 || c == 10);
            sample = (c == 0) ? 8'h77 : 8'hEE;
            if (c == 3) clear_req = 1'b1;
            if (c == 8) clear_req = 1'b0;
            #1;
            chk("c_ready", ready, (c == 0 || c == 18) ? 1 : 0);
            if (c > 0) begin
                chk("c_data", dac_data, (c <= 10) ? 8'h77 : 8'h00);
                chk("c_clr_n", clr_n, (c == 11 || c == 12) ? 0 : 1);
                chk("c_wr_n", wr_n, (c == 2 || c == 3) ? 0 : 1);
                chk("c_busy", busy, ((c >= 1 && c <= 9) || (c >= 11 && c <= 17)) ? 1 : 0);
            end
        end
        valid = 1'b0;
        chk("c_overrun", ovr_cnt, 3);
        $display("clear during write done");

        // enable drops at cycle 2 of a write
        for (int c = 0; c <= 13; c++) begin
            if (c > 0) cyc();
            valid  = (c == 0 || c == 10 || c == 12);
            sample = 8'h42;
            if (c == 2) enable = 1'b0;
            #1;
            chk("d_ready", ready, (c == 0) ? 1 : 0);
            if (c > 0) begin
                chk("d_pd_n", pd_n, (c <= 2) ? 1 : 0);
                chk("d_wr_n", wr_n, (c == 2 || c == 3) ? 0 : 1);
                chk("d_busy", busy, (c <= 9) ? 1 : 0);
                chk("d_data", dac_data, 8'h42);
            end
        end
        chk("d_overrun", ovr_cnt, 5);
        $display("disable mid-write done");

        // Saturation while disabled, then clear with simultaneous drop
        valid = 1'b1;
        repeat (250) cyc();
        chk("e_cnt_250", ovr_cnt, 255);
        repeat (50) cyc();
        chk("e_cnt_sat", ovr_cnt, 255);
        ovr_clr = 1'b1;
        cyc();
        ovr_clr = 1'b0;
        valid   = 1'b0;
        #1;
        chk("e_clr_drop", ovr_cnt, 1);
        cyc();
        chk("e_hold", ovr_cnt, 1);
        ovr_clr = 1'b1;
        cyc();
        ovr_clr = 1'b0;
        #1;
        chk("e_clr", ovr_cnt, 0);
        $display("overrun saturation done");

        // Reset in the middle of the WR_n pulse
        ovr_clr = 1'b1;
        valid   = 1'b1;
        cyc();
        ovr_clr = 1'b0;
        enable  = 1'b1;
        valid   = 1'b0;
        cyc();
        valid  = 1'b1;
        sample = 8'h99;
        cyc();
        valid = 1'b0;
        cyc();
        chk("f_wr_low", wr_n, 0);
        chk("f_data", dac_data, 8'h99);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        #1;
        chk("f_rst_wr_n", wr_n, 1);
        chk("f_rst_busy", busy, 0);
        chk("f_rst_data", dac_data, 0);
        chk("f_rst_clr_n", clr_n, 0);
        cyc();
        chk("f_rel_clr_n", clr_n, 1);
        chk("f_rel_ready", ready, 1);
        $display("reset mid-write done");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
